// File: rtl/inv_decoder_scan_if.sv
// inv_decoder_scan_if
// Bundles the controller-side signals of the inverse decoder into one port.
//   en         : block enable (0 forces every select inactive)
//   mode       : 0 = direct decode, 1 = autonomous scan
//   addr_valid : direct-mode address strobe
//   addr       : direct-mode channel address
//   addr_ready : decoder can take addr this cycle
//   b_n        : one-hot-low channel selects
//   cur_addr   : index of the active channel
//   err        : last accepted direct address was out of range
//   wrap       : one-cycle pulse when scan returns to channel 0
// The master modport is the controller; the slave modport is the decoder.
interface inv_decoder_scan_if #(
   parameter int AW   = 3,
   parameter int NOUT = 6
) ();
   logic            en;
   logic            mode;
   logic            addr_valid;
   logic [AW-1:0]   addr;
   logic            addr_ready;
   logic [NOUT-1:0] b_n;
   logic [AW-1:0]   cur_addr;
   logic            err;
   logic            wrap;

   modport master (
      output en, mode, addr_valid, addr,
      input  addr_ready, b_n, cur_addr, err, wrap
   );

   modport slave (
      input  en, mode, addr_valid, addr,
      output addr_ready, b_n, cur_addr, err, wrap
   );
endinterface

// File: rtl/inv_decoder_scan.sv
// inv_decoder_scan
// Registered active-low decoder with a direct mode (address taken through a
// valid/ready handshake, each selection held at least DWELL cycles) and a
// scan mode (a single low output rotates through all NOUT channels, DWELL
// cycles per channel, with a wrap pulse on return to channel 0).
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : inv_decoder_scan_if slave modport (en, mode, addr_valid, addr in;
//         addr_ready, b_n, cur_addr, err, wrap out)
module inv_decoder_scan #(
   parameter int AW    = 3,
   parameter int NOUT  = 6,
   parameter int DWELL = 4
) (
   input logic              clk,
   input logic              rst,
   inv_decoder_scan_if.slave bus
);

   localparam int              CW      = $clog2(DWELL) + 1;
   localparam logic [AW:0]     NOUT_W  = (AW+1)'(NOUT);
   localparam logic [AW-1:0]   LAST    = AW'(NOUT - 1);
   localparam logic [CW-1:0]   DW_LAST = CW'(DWELL - 1);

   logic [NOUT-1:0] b_n;
   logic [AW-1:0]   cur_addr;
   logic            err;
   logic            wrap;
   logic [CW-1:0]   hold_cnt;
   logic [CW-1:0]   dwell_cnt;
   logic            mode_q;

   logic            addr_ready;
   logic            accept;
   logic            in_range;
   logic            dwell_end;
   logic [AW-1:0]   next_scan;

   // Active-low one-hot of a channel index; indices >= NOUT give all ones.
   function automatic logic [NOUT-1:0] decode_n(input logic [AW-1:0] a);
      logic [NOUT-1:0] v;
      v = '1;
      for (int i = 0; i < NOUT; i++) begin
         if (a == AW'(i)) v[i] = 1'b0;
      end
      return v;
   endfunction

   // The extra MSB lets NOUT = 2^AW compare correctly, so err never fires then.
   assign addr_ready = bus.en & ~bus.mode & (hold_cnt == '0);
   assign accept     = bus.addr_valid & addr_ready;
   assign in_range   = {1'b0, bus.addr} < NOUT_W;
   assign dwell_end  = (dwell_cnt == DW_LAST);
   assign next_scan  = (cur_addr == LAST) ? '0 : cur_addr + AW'(1);

   // mode_q is cleared while disabled, so a scan after en was low re-enters
   // from channel 0 through the same path as a fresh direct-to-scan switch.
   // Leaving scan with no accept blanks the outputs; an accept on that very
   // edge is honoured since addr_ready is already high.
   always_ff @(posedge clk) begin
      if (rst || !bus.en) begin
         b_n       <= '1;
         cur_addr  <= '0;
         err       <= 1'b0;
         wrap      <= 1'b0;
         hold_cnt  <= '0;
         dwell_cnt <= '0;
         mode_q    <= 1'b0;
      end else if (bus.mode) begin
         mode_q   <= 1'b1;
         hold_cnt <= '0;
         if (!mode_q) begin
            cur_addr  <= '0;
            b_n       <= decode_n('0);
            dwell_cnt <= '0;
            err       <= 1'b0;
            wrap      <= 1'b0;
         end else if (dwell_end) begin
            dwell_cnt <= '0;
            cur_addr  <= next_scan;
            b_n       <= decode_n(next_scan);
            wrap      <= (cur_addr == LAST);
         end else begin
            dwell_cnt <= dwell_cnt + CW'(1);
            wrap      <= 1'b0;
         end
      end else begin
         mode_q    <= 1'b0;
         wrap      <= 1'b0;
         dwell_cnt <= '0;
         if (accept) begin
            hold_cnt <= DW_LAST;
            if (in_range) begin
               b_n      <= decode_n(bus.addr);
               cur_addr <= bus.addr;
               err      <= 1'b0;
            end else begin
               b_n <= '1;
               err <= 1'b1;
            end
         end else begin
            if (hold_cnt != '0) hold_cnt <= hold_cnt - CW'(1);
            if (mode_q) b_n <= '1;
         end
      end
   end

   assign bus.addr_ready = addr_ready;
   assign bus.b_n        = b_n;
   assign bus.cur_addr   = cur_addr;
   assign bus.err        = err;
   assign bus.wrap       = wrap;

endmodule

// File: tb/tb_inv_decoder_scan.sv
// tb_inv_decoder_scan
// Self-checking bench for inv_decoder_scan (AW=3, NOUT=6, DWELL=4).
// The driver issues one cycle of stimulus at a time; for each cycle it pushes
// the expected outputs of that cycle (from a behavioural model) onto a queue,
// and a separate monitor pops and compares on the falling edge.
module tb_inv_decoder_scan;

   localparam int AW     = 3;
   localparam int NOUT   = 6;
   localparam int DWELL  = 4;
   localparam int PERIOD = NOUT * DWELL;

   typedef struct {
      logic [NOUT-1:0] b_n;
      logic [AW-1:0]   cur;
      logic            err;
      logic            wrap;
      logic            ready;
   } exp_t;

   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];

   // Model state: outputs seen in the current cycle, plus edges since the
   // last accept and edges since scan entry (-1 when not scanning).
   logic [NOUT-1:0] m_b_n;
   int              m_cur;
   bit              m_err;
   bit              m_wrap;
   int              m_age;
   int              m_scan;
   bit              m_accepted;

   inv_decoder_scan_if #(.AW(AW), .NOUT(NOUT)) bus ();

   inv_decoder_scan #(.AW(AW), .NOUT(NOUT), .DWELL(DWELL)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Global watchdog in case the stimulus ever stalls.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic check_field(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
      end
   endtask

   function automatic bit model_ready(input bit en_i, input bit mode_i);
      return en_i && !mode_i && (m_age >= DWELL);
   endfunction

   // Advance the model across one clock edge using the sampled inputs.
   task automatic model_edge(input bit rst_i, input bit en_i, input bit mode_i,
                             input bit valid_i, input int addr_i);
      m_accepted = 1'b0;
      if (rst_i || !en_i) begin
         m_b_n  = '1;
         m_cur  = 0;
         m_err  = 1'b0;
         m_wrap = 1'b0;
         m_age  = DWELL;
         m_scan = -1;
      end else if (mode_i) begin
         int ch;
         m_scan = m_scan + 1;
         ch     = (m_scan / DWELL) % NOUT;
         m_cur  = ch;
         m_b_n  = '1;
         m_b_n[ch] = 1'b0;
         m_wrap = (m_scan > 0) && (m_scan % PERIOD == 0);
         m_err  = 1'b0;
         m_age  = DWELL;
      end else begin
         m_wrap = 1'b0;
         if (valid_i && (m_age >= DWELL)) begin
            m_accepted = 1'b1;
            m_age      = 1;
            m_b_n      = '1;
            if (addr_i < NOUT) begin
               m_b_n[addr_i] = 1'b0;
               m_cur = addr_i;
               m_err = 1'b0;
            end else begin
               m_err = 1'b1;
            end
         end else begin
            if (m_scan >= 0) m_b_n = '1;
            if (m_age < DWELL) m_age++;
         end
         m_scan = -1;
      end
   endtask

   // Drive one cycle of inputs, record what the DUT must show this cycle,
   // then let the model take the upcoming edge.
   task automatic apply_stimulus(input bit rst_i, input bit en_i, input bit mode_i,
                                 input bit valid_i, input int addr_i);
      exp_t e;
      @(posedge clk);
      #1;
      rst            = rst_i;
      bus.en         = en_i;
      bus.mode       = mode_i;
      bus.addr_valid = valid_i;
      bus.addr       = AW'(addr_i);
      e.b_n   = m_b_n;
      e.cur   = AW'(m_cur);
      e.err   = m_err;
      e.wrap  = m_wrap;
      e.ready = model_ready(en_i, mode_i);
      exp_q.push_back(e);
      model_edge(rst_i, en_i, mode_i, valid_i, addr_i);
   endtask

   // Hold valid with an address until the handshake completes.
   task automatic send_addr(input int a);
      int budget = 0;
      do begin
         apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, a);
         budget++;
      end while (!m_accepted && budget < 20);
      if (!m_accepted) check_field("accept_timeout", 32'd0, 32'd1);
   endtask

   // Monitor: compare every cycle's outputs against the queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_field("b_n",        bus.b_n,        e.b_n);
            check_field("cur_addr",   bus.cur_addr,   e.cur);
            check_field("err",        bus.err,        e.err);
            check_field("wrap",       bus.wrap,       e.wrap);
            check_field("addr_ready", bus.addr_ready, e.ready);
            check_field("one_low",    32'($countones(~bus.b_n) <= 1), 32'd1);
         end
      end
   end

   initial begin
      int drain;
      bit r_en, r_mode;
      rst            = 1'b1;
      bus.en         = 1'b0;
      bus.mode       = 1'b0;
      bus.addr_valid = 1'b0;
      bus.addr       = '0;
      m_b_n  = '1;
      m_cur  = 0;
      m_err  = 1'b0;
      m_wrap = 1'b0;
      m_age  = DWELL;
      m_scan = -1;
      m_accepted = 1'b0;
      repeat (2) @(posedge clk);

      // Reset state, then idle direct mode.
      apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 0);
      repeat (3) apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 0);

      // Direct decode of every legal channel.
      for (int a = 0; a < NOUT; a++) send_addr(a);

      // Out-of-range addresses, then a legal one clears err.
      send_addr(6);
      send_addr(7);
      send_addr(2);
      repeat (4) apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 0);

      // Scan for 30 cycles past entry, covering one wrap.
      repeat (31) apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 0);

      // Back to direct, re-enter scan, drop en while channel 3 is active.
      apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 0);
      repeat (14) apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 0);
      apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 0);
      repeat (10) apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 0);

      // Reset in the middle of a direct hold.
      apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 0);
      send_addr(4);
      apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 0);
      apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 0);
      repeat (2) apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 0);

      // Randomized mix of modes, enables, strobes and occasional resets.
      r_en   = 1'b1;
      r_mode = 1'b0;
      for (int i = 0; i < 500; i++) begin
         if ($urandom_range(0, 39) == 0) r_mode = ~r_mode;
         r_en = ($urandom_range(0, 29) != 0);
         apply_stimulus($urandom_range(0, 99) == 0, r_en, r_mode,
                        $urandom_range(0, 1) == 1, int'($urandom_range(0, 7)));
      end
      apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 0);

      // Let the monitor consume everything still queued.
      drain = 0;
      while (exp_q.size() > 0 && drain < 10) begin
         @(negedge clk);
         drain++;
      end
      #1;
      if (exp_q.size() > 0) check_field("queue_drain", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
